// File: rtl/bf_program_loader_if.sv
// Character-source handshake and program-memory write port of the Brainfuck program loader.
interface bf_program_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        char_in;
  logic              char_valid;
  logic              char_ready;
  logic              eop;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;

  modport master (
    input  char_in, char_valid, eop,
    output char_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output char_in, char_valid, eop,
    input  char_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/bf_program_loader.sv
// Loads Brainfuck source into program memory as 4-bit opcodes, checks brackets/capacity, appends stop.
// Optional macro BF_LOADER_STRICT_EN: unknown non-whitespace characters abort the load with code 4.
module bf_program_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  bf_program_loader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code,
  output logic [ADDR_W-1:0] prog_len
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TERM, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_ONE = (ADDR_W + 1)'(1);
  localparam logic [3:0]        OP_OPEN   = 4'h4;
  localparam logic [3:0]        OP_CLOSE  = 4'h5;
  localparam logic [3:0]        OP_STOP   = 4'hF;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   depth;
  logic              is_cmd;
  logic [3:0]        opcode;
  logic              bad_char;
  logic              hs;
  logic [2:0]        err_nxt;

  always_comb begin
    is_cmd = 1'b1;
    opcode = 4'h0;
    case (bus.char_in)
      8'h3C:   opcode = 4'h0;  // <
      8'h3E:   opcode = 4'h1;  // >
      8'h2B:   opcode = 4'h2;  // +
      8'h2D:   opcode = 4'h3;  // -
      8'h5B:   opcode = 4'h4;  // [
      8'h5D:   opcode = 4'h5;  // ]
      8'h2E:   opcode = 4'h6;  // .
      8'h2C:   opcode = 4'h7;  // ,
      default: is_cmd = 1'b0;
    endcase
  end

`ifdef BF_LOADER_STRICT_EN
  always_comb begin
    bad_char = !is_cmd && !(bus.char_in inside {8'h20, 8'h09, 8'h0A, 8'h0D});
  end
`else
  always_comb begin
    bad_char = 1'b0;
  end
`endif

  // eop takes priority: a character presented alongside it is never consumed
  assign hs = (state == S_LOAD) && bus.char_valid && !bus.eop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = '0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (bus.eop) begin
          if (depth != '0) begin
            state_nxt = S_ERR;
            err_nxt   = 3'd2;
          end else begin
            state_nxt = S_TERM;
          end
        end else if (hs) begin
          if (is_cmd) begin
            if (ptr == LAST_SLOT) begin
              state_nxt = S_ERR;
              err_nxt   = 3'd3;
            end else if (opcode == OP_CLOSE && depth == '0) begin
              state_nxt = S_ERR;
              err_nxt   = 3'd1;
            end
          end else if (bad_char) begin
            state_nxt = S_ERR;
            err_nxt   = 3'd4;
          end
        end
      end
      S_TERM:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.char_ready = (state == S_LOAD) && !bus.eop;
    busy           = (state == S_LOAD) || (state == S_TERM);
    done           = (state == S_DONE);
    error          = (state == S_ERR);
  end

  // The stop word is registered on the eop edge so its strobe lands in the TERM cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      depth       <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      err_code    <= '0;
      prog_len    <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            ptr      <= '0;
            depth    <= '0;
            err_code <= '0;
            prog_len <= '0;
          end
        end
        S_LOAD: begin
          if (state_nxt == S_ERR) begin
            err_code <= err_nxt;
          end else if (state_nxt == S_TERM) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= ptr;
            bus.wr_data <= OP_STOP;
            prog_len    <= ptr;
          end else if (hs && is_cmd) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= ptr;
            bus.wr_data <= opcode;
            ptr         <= ptr + PTR_ONE;
            if (opcode == OP_OPEN)       depth <= depth + DEPTH_ONE;
            else if (opcode == OP_CLOSE) depth <= depth - DEPTH_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
